// File: rtl/vc_arb3_sd_ctrl_if.sv
// Handshake bundle between the three requesters, the shared downstream channel and the
// same-domain arbiter. The slave modport is the arbiter's view of the bundle.
interface vc_arb3_sd_ctrl_if;
  logic [1:0] domain;
  logic       in0_val;
  logic       in0_last;
  logic       in0_rdy;
  logic       in1_val;
  logic       in1_last;
  logic       in1_rdy;
  logic       in2_val;
  logic       in2_last;
  logic       in2_rdy;
  logic       out_val;
  logic       out_last;
  logic       out_rdy;
  logic [1:0] sel;
  logic [1:0] cur_domain;
  logic       busy;
  logic       err;

  modport master (
    output domain, in0_val, in0_last, in1_val, in1_last, in2_val, in2_last, out_rdy,
    input  in0_rdy, in1_rdy, in2_rdy, out_val, out_last, sel, cur_domain, busy, err
  );

  modport slave (
    input  domain, in0_val, in0_last, in1_val, in1_last, in2_val, in2_last, out_rdy,
    output in0_rdy, in1_rdy, in2_rdy, out_val, out_last, sel, cur_domain, busy, err
  );
endinterface

// File: rtl/vc_arb3_sd_ctrl.sv
// Round-robin, packet-locking arbiter for three requesters sharing one val/rdy channel.
// Only requesters in the active security domain compete; domain switches happen between packets.
module vc_arb3_sd_ctrl #(
  parameter logic [1:0]  p_dom0      = 2'd0,
  parameter logic [1:0]  p_dom1      = 2'd1,
  parameter logic [1:0]  p_dom2      = 2'd2,
  parameter int unsigned p_max_beats = 16
) (
  input  logic               clk,
  input  logic               reset,
  vc_arb3_sd_ctrl_if.slave   bus
);

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } state_t;

  localparam logic [7:0] c_max_beats = 8'(p_max_beats);
  localparam logic [5:0] c_doms      = {p_dom2, p_dom1, p_dom0};

  state_t     r_state;
  state_t     w_state_next;
  logic [1:0] r_grant;
  logic [1:0] w_grant_next;
  logic [1:0] r_ptr;
  logic [1:0] w_ptr_next;
  logic [1:0] r_cur_domain;
  logic [1:0] w_cur_domain_next;
  logic [7:0] r_beat_cnt;
  logic [7:0] w_beat_cnt_next;
  logic       r_err;
  logic       w_err_next;

  // Padded to four entries so a 2-bit grant/candidate index is always in range.
  logic [3:0] w_val4;
  logic [3:0] w_last4;
  logic [3:0] w_elig4;
  logic [2:0] w_rdy;
  logic [1:0] w_cand [3];
  logic [1:0] w_pick;
  logic       w_any;
  logic       w_locked;
  logic       w_gval;
  logic       w_glast;
  logic       w_xfer;

  function automatic logic [1:0] inc3(input logic [1:0] v);
    return (v == 2'd2) ? 2'd0 : v + 2'd1;
  endfunction

  assign w_val4  = {1'b0, bus.in2_val,  bus.in1_val,  bus.in0_val};
  assign w_last4 = {1'b0, bus.in2_last, bus.in1_last, bus.in0_last};
  assign w_elig4[3] = 1'b0;

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_req
      assign w_elig4[gi] = w_val4[gi] && (c_doms[2*gi +: 2] == r_cur_domain);
      assign w_rdy[gi]   = w_locked && (r_grant == 2'(gi)) && bus.out_rdy;
    end
  endgenerate

  assign w_cand[0] = r_ptr;
  assign w_cand[1] = inc3(r_ptr);
  assign w_cand[2] = inc3(w_cand[1]);

  // Scan from the highest offset down so the candidate closest to ptr wins.
  always_comb begin
    w_any  = 1'b0;
    w_pick = r_ptr;
    for (int k = 2; k >= 0; k--) begin
      if (w_elig4[w_cand[k]]) begin
        w_pick = w_cand[k];
        w_any  = 1'b1;
      end
    end
  end

  assign w_locked = (r_state == ST_LOCKED);
  assign w_gval   = w_val4[r_grant];
  assign w_glast  = w_last4[r_grant];
  assign w_xfer   = w_locked && w_gval && bus.out_rdy;

  always_comb begin
    w_state_next      = r_state;
    w_grant_next      = r_grant;
    w_ptr_next        = r_ptr;
    w_cur_domain_next = r_cur_domain;
    w_beat_cnt_next   = r_beat_cnt;
    w_err_next        = r_err;
    case (r_state)
      ST_IDLE: begin
        // A domain change consumes this IDLE cycle; arbitration resumes next cycle.
        if (bus.domain != r_cur_domain) begin
          w_cur_domain_next = bus.domain;
        end else if (w_any) begin
          w_grant_next    = w_pick;
          w_beat_cnt_next = 8'd0;
          w_state_next    = ST_LOCKED;
        end
      end
      ST_LOCKED: begin
        if (w_xfer) begin
          w_beat_cnt_next = r_beat_cnt + 8'd1;
          if (w_glast) begin
            w_state_next = ST_IDLE;
            w_ptr_next   = inc3(r_grant);
          end else if (r_beat_cnt + 8'd1 == c_max_beats) begin
            w_state_next = ST_IDLE;
            w_ptr_next   = inc3(r_grant);
            w_err_next   = 1'b1;
          end
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= ST_IDLE;
      r_grant      <= 2'd0;
      r_ptr        <= 2'd0;
      r_cur_domain <= 2'd0;
      r_beat_cnt   <= 8'd0;
      r_err        <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_grant      <= w_grant_next;
      r_ptr        <= w_ptr_next;
      r_cur_domain <= w_cur_domain_next;
      r_beat_cnt   <= w_beat_cnt_next;
      r_err        <= w_err_next;
    end
  end

  assign bus.sel        = r_grant;
  assign bus.out_val    = w_locked && w_gval;
  assign bus.out_last   = w_locked && w_glast;
  assign bus.in0_rdy    = w_rdy[0];
  assign bus.in1_rdy    = w_rdy[1];
  assign bus.in2_rdy    = w_rdy[2];
  assign bus.cur_domain = r_cur_domain;
  assign bus.busy       = w_locked;
  assign bus.err        = r_err;

endmodule

// File: tb/tb_vc_arb3_sd_ctrl.sv
// Bench for vc_arb3_sd_ctrl: a cycle table on a split-domain instance (max 4 beats)
// and a grant-order scoreboard on an all-domain-0 instance.
module tb_vc_arb3_sd_ctrl;

  typedef struct {
    logic       rst_n;
    logic [1:0] dom;
    logic [2:0] val;
    logic [2:0] last;
    logic       ordy;
    logic [10:0] exp;  // {sel, out_val, out_last, rdy[2:0], busy, cur_domain, err}
  } vec_t;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_fail;
  vec_t vecs[$];
  int   exp_q[$];

  vc_arb3_sd_ctrl_if ifa ();
  vc_arb3_sd_ctrl_if ifb ();

  vc_arb3_sd_ctrl #(.p_dom0(2'd0), .p_dom1(2'd1), .p_dom2(2'd2), .p_max_beats(4)) u_dut_a (
    .clk   (clk),
    .reset (reset),
    .bus   (ifa.slave)
  );

  vc_arb3_sd_ctrl #(.p_dom0(2'd0), .p_dom1(2'd0), .p_dom2(2'd0), .p_max_beats(16)) u_dut_b (
    .clk   (clk),
    .reset (reset),
    .bus   (ifb.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endtask

  task automatic add(input logic r, input logic [1:0] d, input logic [2:0] v, input logic [2:0] l,
                     input logic o, input logic [1:0] s, input logic ov, input logic ol,
                     input logic [2:0] rdy, input logic b, input logic [1:0] cd, input logic e);
    vec_t t;
    t.rst_n = r; t.dom = d; t.val = v; t.last = l; t.ordy = o;
    t.exp   = {s, ov, ol, rdy, b, cd, e};
    vecs.push_back(t);
  endtask

  task automatic drive_a(input vec_t t);
    reset        = t.rst_n;
    ifa.domain   = t.dom;
    ifa.in0_val  = t.val[0]; ifa.in1_val  = t.val[1]; ifa.in2_val  = t.val[2];
    ifa.in0_last = t.last[0]; ifa.in1_last = t.last[1]; ifa.in2_last = t.last[2];
    ifa.out_rdy  = t.ordy;
  endtask

  task automatic drive_b(input logic [2:0] v, input logic [2:0] l);
    ifb.in0_val  = v[0]; ifb.in1_val  = v[1]; ifb.in2_val  = v[2];
    ifb.in0_last = l[0]; ifb.in1_last = l[1]; ifb.in2_last = l[2];
  endtask

  function automatic logic [10:0] pack_a();
    return {ifa.sel, ifa.out_val, ifa.out_last, ifa.in2_rdy, ifa.in1_rdy, ifa.in0_rdy,
            ifa.busy, ifa.cur_domain, ifa.err};
  endfunction

  // Samples ifb each cycle; every transfer pops the next expected grant index.
  task automatic run_sb(input string tag, input int budget);
    int last_c;
    logic [2:0] rdy;
    last_c = -1;
    for (int c = 0; c < budget && exp_q.size() > 0; c++) begin
      #1;
      if (ifb.out_val && ifb.out_rdy) begin
        int e;
        e = exp_q.pop_front();
        rdy = {ifb.in2_rdy, ifb.in1_rdy, ifb.in0_rdy};
        $display("%s beat cycle=%0d sel=%0d exp=%0d rdy=%b", tag, c, ifb.sel, e, rdy);
        chk({tag, "_sel"}, 32'(ifb.sel), 32'(e));
        chk({tag, "_rdy"}, 32'(rdy), 32'(3'b001 << e));
        if (last_c >= 0) chk({tag, "_gap"}, 32'(c - last_c), 32'd2);
        last_c = c;
      end
      @(negedge clk);
    end
    if (exp_q.size() != 0) begin
      chk({tag, "_timeout_left"}, 32'(exp_q.size()), 32'd0);
      exp_q.delete();
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset    = 1'b0;
    ifb.domain = 2'd0;
    ifb.out_rdy = 1'b1;
    drive_b(3'b000, 3'b000);

    //   rst dom val     last    rdy | sel ov ol rdy    busy cd err
    add(0, 0, 3'b111, 3'b000, 1,  0, 0, 0, 3'b000, 0, 0, 0);  // reset, all vals high
    add(0, 0, 3'b111, 3'b000, 1,  0, 0, 0, 3'b000, 0, 0, 0);
    add(1, 0, 3'b001, 3'b000, 1,  0, 0, 0, 3'b000, 0, 0, 0);  // request seen, no comb grant
    add(1, 0, 3'b001, 3'b000, 1,  0, 1, 0, 3'b001, 1, 0, 0);  // beat 1
    add(1, 0, 3'b001, 3'b000, 1,  0, 1, 0, 3'b001, 1, 0, 0);  // beat 2
    add(1, 0, 3'b001, 3'b001, 1,  0, 1, 1, 3'b001, 1, 0, 0);  // beat 3, last
    add(1, 0, 3'b000, 3'b000, 1,  0, 0, 0, 3'b000, 0, 0, 0);  // released
    add(1, 1, 3'b011, 3'b000, 1,  0, 0, 0, 3'b000, 0, 0, 0);  // switch cycle 0->1
    add(1, 1, 3'b011, 3'b000, 1,  0, 0, 0, 3'b000, 0, 1, 0);  // grants in1 only
    add(1, 2, 3'b011, 3'b000, 1,  1, 1, 0, 3'b010, 1, 1, 0);  // switch request deferred
    add(1, 2, 3'b011, 3'b010, 1,  1, 1, 1, 3'b010, 1, 1, 0);
    add(1, 2, 3'b111, 3'b000, 1,  1, 0, 0, 3'b000, 0, 1, 0);  // switch cycle 1->2
    add(1, 2, 3'b111, 3'b000, 1,  1, 0, 0, 3'b000, 0, 2, 0);  // grants in2 only
    add(1, 2, 3'b111, 3'b100, 1,  2, 1, 1, 3'b100, 1, 2, 0);
    add(1, 0, 3'b000, 3'b000, 1,  2, 0, 0, 3'b000, 0, 2, 0);  // switch 2->0
    add(1, 0, 3'b001, 3'b000, 1,  2, 0, 0, 3'b000, 0, 0, 0);
    add(1, 0, 3'b001, 3'b000, 1,  0, 1, 0, 3'b001, 1, 0, 0);  // xfer 1
    add(1, 0, 3'b001, 3'b000, 0,  0, 1, 0, 3'b000, 1, 0, 0);
    add(1, 0, 3'b001, 3'b000, 1,  0, 1, 0, 3'b001, 1, 0, 0);  // xfer 2
    add(1, 0, 3'b001, 3'b000, 0,  0, 1, 0, 3'b000, 1, 0, 0);
    add(1, 0, 3'b001, 3'b000, 1,  0, 1, 0, 3'b001, 1, 0, 0);  // xfer 3
    add(1, 0, 3'b001, 3'b000, 0,  0, 1, 0, 3'b000, 1, 0, 0);
    add(1, 0, 3'b001, 3'b000, 1,  0, 1, 0, 3'b001, 1, 0, 0);  // xfer 4, forced release
    add(1, 0, 3'b001, 3'b000, 1,  0, 0, 0, 3'b000, 0, 0, 1);  // err sticky
    add(1, 0, 3'b000, 3'b000, 1,  0, 0, 0, 3'b001, 1, 0, 1);  // val dropped, lock kept
    add(1, 0, 3'b001, 3'b001, 1,  0, 1, 1, 3'b001, 1, 0, 1);
    add(1, 0, 3'b001, 3'b000, 1,  0, 0, 0, 3'b000, 0, 0, 1);
    add(1, 0, 3'b001, 3'b000, 1,  0, 1, 0, 3'b001, 1, 0, 1);  // mid-packet
    add(0, 0, 3'b001, 3'b000, 1,  0, 0, 0, 3'b000, 0, 0, 0);  // async reset truncates
    add(1, 0, 3'b000, 3'b000, 1,  0, 0, 0, 3'b000, 0, 0, 0);

    foreach (vecs[i]) begin
      logic [10:0] act;
      @(negedge clk);
      drive_a(vecs[i]);
      #1;
      act = pack_a();
      $display("row %0d rst=%b dom=%0d val=%b last=%b ordy=%b -> out=%h exp=%h",
               i, vecs[i].rst_n, vecs[i].dom, vecs[i].val, vecs[i].last, vecs[i].ordy,
               act, vecs[i].exp);
      chk($sformatf("row%0d", i), 32'(act), 32'(vecs[i].exp));
    end

    // Round-robin over three always-valid 1-beat requesters.
    @(negedge clk);
    exp_q.push_back(0); exp_q.push_back(1); exp_q.push_back(2);
    exp_q.push_back(0); exp_q.push_back(1);
    drive_b(3'b111, 3'b111);
    run_sb("rr", 40);

    // After in1 releases, ptr=2: in2 must beat in0.
    drive_b(3'b101, 3'b111);
    exp_q.push_back(2); exp_q.push_back(0);
    run_sb("ptr", 20);
    drive_b(3'b000, 3'b000);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
